apb_arbiter: RTL

Two-requester APB master front end. It shares the single APB bus between the instruction-fetch port (m0) and the load/store port (m1) of the core, and drives the address decoder that fans out to sram/uart/system.
- Sequences APB SETUP/ACCESS phases.
- Round-robin arbitration between the two ports.
- Watchdog terminates a stalled slave with an error.

---
 rtl/apb_arb_pkg.sv | 35 +++
 rtl/apb_watchdog.sv | 38 +++
 rtl/apb_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-port APB arbiter.
// The FSM state encoding and port indices live here so the top and
// any future monitors agree on them.
package apb_arb_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Requester indices
  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;

  // Round-robin pick between the two requesters.
  // When both request, the port that did not win last time is chosen.
  // The result is only meaningful when at least one request is high.
  function automatic logic rr_pick(input logic req0,
                                   input logic req1,
                                   input logic last_grant);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = PORT_LSU;
    end else begin
      pick = PORT_IFETCH;
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog. Counts stalled cycles while enabled and flags
// expiry once the count reaches TIMEOUT-1, so the owning FSM spends at
// most TIMEOUT cycles in ACCESS. TIMEOUT=0 removes the counter entirely.
module apb_watchdog #(
  parameter int TIMEOUT  = 256,
  parameter int TO_WIDTH = $clog2(TIMEOUT + 1)
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam logic [TO_WIDTH-1:0] LAST_COUNT = TO_WIDTH'(TIMEOUT - 1);

      logic [TO_WIDTH-1:0] count_reg;

      assign expired = (count_reg == LAST_COUNT);

      // Stall counter: cleared outside ACCESS, saturates at the limit
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable && !expired) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end else begin : g_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master front end. Arbitrates round-robin between the
// instruction-fetch port (m0) and the load/store port (m1), runs the
// SETUP/ACCESS phases on the shared bus and returns a one-cycle done
// pulse with read data and error status to the winning port.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256,
  parameter int TO_WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic                  pclk,
  input  logic                  presetn,
  // requester 0: instruction fetch
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_write,
  input  logic [3:0]            m0_strb,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  // requester 1: load/store
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_write,
  input  logic [3:0]            m1_strb,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  // APB master side
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  state_e state_reg;
  logic   grant_reg;
  logic   last_grant_reg;

  logic                  any_req;
  logic                  grant_next;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_write;
  logic [3:0]            sel_strb;

  logic                  wd_clear;
  logic                  wd_enable;
  logic                  wd_expired;

  logic                  access_end;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  assign any_req = m0_req | m1_req;

  // Winner selection and attribute mux for the port that would be granted
  always_comb begin
    grant_next = rr_pick(m0_req, m1_req, last_grant_reg);
    if (grant_next == PORT_LSU) begin
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_write = m1_write;
      sel_strb  = m1_strb;
    end else begin
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_write = m0_write;
      sel_strb  = m0_strb;
    end
  end

  // ACCESS termination: a real pready always beats a simultaneous timeout
  always_comb begin
    access_end = pready | wd_expired;
    if (pready) begin
      resp_rdata = prdata;
      resp_err   = perr;
    end else begin
      resp_rdata = '0;
      resp_err   = 1'b1;
    end
  end

  assign wd_clear  = (state_reg != ACCESS);
  assign wd_enable = (state_reg == ACCESS) && !pready;

  apb_watchdog #(
    .TIMEOUT  (TIMEOUT),
    .TO_WIDTH (TO_WIDTH)
  ) u_watchdog (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Transfer FSM with registered bus and response outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg      <= IDLE;
      grant_reg      <= PORT_IFETCH;
      last_grant_reg <= PORT_LSU;
      paddr          <= '0;
      pdata          <= '0;
      pwrite         <= 1'b0;
      pstb           <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      m0_done        <= 1'b0;
      m0_rdata       <= '0;
      m0_err         <= 1'b0;
      m1_done        <= 1'b0;
      m1_rdata       <= '0;
      m1_err         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg      <= grant_next;
            last_grant_reg <= grant_next;
            paddr          <= sel_addr;
            pdata          <= sel_wdata;
            pwrite         <= sel_write;
            pstb           <= sel_strb;
            psel           <= 1'b1;
            penable        <= 1'b0;
            state_reg      <= SETUP;
          end
        end

        SETUP: begin
          penable   <= 1'b1;
          state_reg <= ACCESS;
        end

        ACCESS: begin
          if (access_end) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state_reg <= RESP;
            if (grant_reg == PORT_LSU) begin
              m1_done  <= 1'b1;
              m1_rdata <= resp_rdata;
              m1_err   <= resp_err;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= resp_rdata;
              m0_err   <= resp_err;
            end
          end
        end

        RESP: begin
          m0_done   <= 1'b0;
          m1_done   <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          m0_done   <= 1'b0;
          m1_done   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
